// File: rtl/y_pixel_filling_pkg.sv
// Shared constants, pixel-set value and FSM state encoding for y_pixel_filling.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package y_pixel_filling_pkg;

  localparam int          IMAGE_WIDTH_DEF = 320;
  localparam int          IMAGE_HEIGHT    = 240;
  localparam int          START_ADDR_DEF  = 2240;   // first 7 lines skipped
  localparam int          END_ADDR_DEF    = 74560;  // last lines are garbage
  localparam int          ADDR_W          = 18;
  localparam int          DATA_W          = 32;
  localparam logic [31:0] PIXEL_SET       = 32'd1;

  typedef enum logic [2:0] {
    IDLE,
    RD_C,
    RD_B,
    RD_A,
    CAP_A,
    WRITE,
    DONE
  } fill_state_t;

endpackage

// File: rtl/y_pixel_filling_if.sv
// Single-port RAM bus between the y-filling engine (master) and the frame RAM (slave).
// Latency: read data returns one cycle after an address is presented with wren=0.
// Backpressure: none on the bus; the master stalls internally via pause.
//   data_read  : RAM -> master read word
//   wren       : write strobe
//   data_write : write word
//   address    : word address
interface y_pixel_filling_if;
  import y_pixel_filling_pkg::*;

  logic [DATA_W-1:0] data_read;
  logic              wren;
  logic [DATA_W-1:0] data_write;
  logic [ADDR_W-1:0] address;

  modport master (input data_read, output wren, output data_write, output address);
  modport slave  (output data_read, input wren, input data_write, input address);

endinterface

// File: rtl/y_pixel_filling.sv
// Raster pass that sets a pixel to 1 when the pixels directly above and below are 1 and it is not.
// Latency: 4 cycles per unchanged pixel, 5 per filled pixel (paused cycles excluded).
// Backpressure: pause freezes all state and masks wren; a held WRITE is reissued on resume.
// Ports: clk_div_by_two / reset_n (async, active low); pause, enable_y_pixel_filling control;
//        ram (master modport) carries address/wren/data_write out and data_read in;
//        fill_count = pixels filled this/last pass; y_pixel_filling_done = pass complete.
module y_pixel_filling
  import y_pixel_filling_pkg::*;
#(
  parameter int IMAGE_WIDTH = IMAGE_WIDTH_DEF,
  parameter int START_ADDR  = START_ADDR_DEF,
  parameter int END_ADDR    = END_ADDR_DEF
) (
  input  logic                clk_div_by_two,
  input  logic                reset_n,
  input  logic                pause,
  input  logic                enable_y_pixel_filling,
  y_pixel_filling_if.master   ram,
  output logic [ADDR_W-1:0]   fill_count,
  output logic                y_pixel_filling_done
);

  if (START_ADDR < IMAGE_WIDTH || END_ADDR < START_ADDR ||
      END_ADDR + IMAGE_WIDTH >= (1 << ADDR_W)) begin : g_param_check
    $error("y_pixel_filling: illegal IMAGE_WIDTH/START_ADDR/END_ADDR combination");
  end

  localparam logic [ADDR_W-1:0] STRIDE    = IMAGE_WIDTH[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] P_FIRST   = START_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] P_LAST    = END_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] CNT_MAX   = {ADDR_W{1'b1}};

  fill_state_t        state, state_nxt;
  logic [ADDR_W-1:0]  p, p_nxt;
  logic [DATA_W-1:0]  center, center_nxt;
  logic [DATA_W-1:0]  below, below_nxt;
  logic [DATA_W-1:0]  above, above_nxt;
  logic [ADDR_W-1:0]  cnt_nxt;
  logic               fill_hit;

  // In CAP_A the "above" word is still on data_read, so it is compared directly.
  assign fill_hit = (ram.data_read == PIXEL_SET) && (below == PIXEL_SET) &&
                    (center != PIXEL_SET);

  always_ff @(posedge clk_div_by_two or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      p          <= '0;
      center     <= '0;
      below      <= '0;
      above      <= '0;
      fill_count <= '0;
    end else if (!pause) begin
      state      <= state_nxt;
      p          <= p_nxt;
      center     <= center_nxt;
      below      <= below_nxt;
      above      <= above_nxt;
      fill_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    p_nxt      = p;
    center_nxt = center;
    below_nxt  = below;
    above_nxt  = above;
    cnt_nxt    = fill_count;
    if (!enable_y_pixel_filling) begin
      // Abort/clear: fill_count is kept so the last result stays readable.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          p_nxt     = P_FIRST;
          cnt_nxt   = '0;
          state_nxt = RD_C;
        end
        RD_C: state_nxt = RD_B;
        RD_B: begin
          center_nxt = ram.data_read;
          state_nxt  = RD_A;
        end
        RD_A: begin
          below_nxt = ram.data_read;
          state_nxt = CAP_A;
        end
        CAP_A: begin
          above_nxt = ram.data_read;
          if (fill_hit)          state_nxt = WRITE;
          else if (p == P_LAST)  state_nxt = DONE;
          else begin
            p_nxt     = p + 18'd1;
            state_nxt = RD_C;
          end
        end
        WRITE: begin
          if (fill_count != CNT_MAX) cnt_nxt = fill_count + 18'd1;
          if (p == P_LAST) state_nxt = DONE;
          else begin
            p_nxt     = p + 18'd1;
            state_nxt = RD_C;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from state so an async reset clears them without an edge.
  always_comb begin
    ram.address    = '0;
    ram.data_write = '0;
    ram.wren       = 1'b0;
    case (state)
      RD_C:  ram.address = p;
      RD_B:  ram.address = p + STRIDE;
      RD_A:  ram.address = p - STRIDE;
      WRITE: begin
        ram.address    = p;
        ram.data_write = PIXEL_SET;
        ram.wren       = !pause;
      end
      default: ;
    endcase
  end

  assign y_pixel_filling_done = (state == DONE);

endmodule

// File: tb/tb_y_pixel_filling.sv
module tb_y_pixel_filling;
  import y_pixel_filling_pkg::*;

  localparam int W     = 320;
  localparam int START = 2240;
  localparam int LAST  = 3200;              // short frame keeps passes ~4k cycles
  localparam int NPIX  = LAST - START + 1;  // 961
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause;
  logic        enable;
  logic [17:0] fill_count;
  logic        done;

  y_pixel_filling_if ram_bus ();

  y_pixel_filling #(.IMAGE_WIDTH(W), .START_ADDR(START), .END_ADDR(LAST)) dut (
    .clk_div_by_two         (clk),
    .reset_n                (reset_n),
    .pause                  (pause),
    .enable_y_pixel_filling (enable),
    .ram                    (ram_bus),
    .fill_count             (fill_count),
    .y_pixel_filling_done   (done)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, 1-cycle read latency; image preload via load_pend.
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] img [0:DEPTH-1];
  logic [31:0] rd_q = '0;
  logic        load_pend = 1'b0;
  int          n_writes = 0;
  logic [17:0] last_waddr = '0;

  always @(posedge clk) begin
    if (load_pend) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
    end else if (ram_bus.wren) begin
      mem[ram_bus.address[11:0]] <= ram_bus.data_write;
    end
    rd_q <= mem[ram_bus.address[11:0]];
  end

  always @(posedge clk) begin
    if (ram_bus.wren) begin
      n_writes   <= n_writes + 1;
      last_waddr <= ram_bus.address;
    end
  end

  assign ram_bus.data_read = rd_q;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // kind 0: all zero; 1: 1/0/1 vertical triple at 2560/2880/3200; 2: column patterns
  task automatic load_img(input int kind);
    for (int i = 0; i < DEPTH; i++) img[i] = '0;
    if (kind == 1) begin
      img[2560] = 32'd1;
      img[3200] = 32'd1;
    end else if (kind == 2) begin
      for (int r = 6; r <= 11; r++) img[r*W + 5] = (r % 2 == 0) ? 32'd1 : 32'd0;
      img[6*W + 9]  = 32'h101;  img[8*W + 9]  = 32'd1;
      img[6*W + 12] = 32'd1;    img[7*W + 12] = 32'd2;  img[8*W + 12] = 32'd1;
      img[6*W + 15] = 32'd1;    img[7*W + 15] = 32'd1;  img[8*W + 15] = 32'd1;
    end
    load_pend = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_pend = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns edges from the start edge to DONE.
  task automatic run_pass(input bit pause_at_write, output int cyc);
    bit paused = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    chk("first_addr", ram_bus.address, START);
    chk("first_cnt", fill_count, 0);
    while (cyc < 6000) begin
      if (done) break;
      if (pause_at_write && !paused && ram_bus.wren) begin
        paused = 1'b1;
        pause  = 1'b1;
        #1;
        chk("pause_wren_0", ram_bus.wren, 0);
        chk("pause_addr_0", ram_bus.address, 2880);
        repeat (10) begin
          @(posedge clk);
          cyc++;
        end
        @(negedge clk);
        chk("pause_wren_9", ram_bus.wren, 0);
        chk("pause_addr_9", ram_bus.address, 2880);
        chk("pause_data_9", ram_bus.data_write, 1);
        chk("pause_nowr", n_writes - 0 == n_writes ? fill_count : 18'h3ffff, 0);
        pause = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("pass_done", done, 1);
    chk("done_wren", ram_bus.wren, 0);
  endtask

  task automatic end_pass(input int exp_cnt);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_cnt_hold", fill_count, exp_cnt);
  endtask

  int cyc;
  int w0;

  initial begin
    reset_n = 1'b0;
    pause   = 1'b0;
    enable  = 1'b0;
    #1;
    chk("rst_wren", ram_bus.wren, 0);
    chk("rst_addr", ram_bus.address, 0);
    chk("rst_data", ram_bus.data_write, 0);
    chk("rst_cnt", fill_count, 0);
    chk("rst_done", done, 0);
    load_img(0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single vertical gap: only 2880 (1 above at 2560, 1 below at 3200) is filled.
    load_img(1);
    w0 = n_writes;
    run_pass(1'b0, cyc);
    chk("t1_cycles", cyc, 4*NPIX + 1);
    chk("t1_cnt", fill_count, 1);
    chk("t1_writes", n_writes - w0, 1);
    chk("t1_waddr", last_waddr, 2880);
    chk("t1_mem", mem[2880], 1);
    end_pass(1);

    // All-zero frame: no writes, exactly 4 cycles per pixel.
    load_img(0);
    w0 = n_writes;
    run_pass(1'b0, cyc);
    chk("t2_cycles", cyc, 4*NPIX);
    chk("t2_cnt", fill_count, 0);
    chk("t2_writes", n_writes - w0, 0);
    end_pass(0);

    // Column patterns: fills at 2245, 2885 and 2252 (center 2 counts as not-1).
    load_img(2);
    w0 = n_writes;
    run_pass(1'b0, cyc);
    chk("t3_cycles", cyc, 4*NPIX + 3);
    chk("t3_cnt", fill_count, 3);
    chk("t3_writes", n_writes - w0, 3);
    chk("t3_m2245", mem[7*W + 5], 1);
    chk("t3_m2885", mem[9*W + 5], 1);
    chk("t3_m2252", mem[7*W + 12], 1);
    chk("t3_m2249", mem[7*W + 9], 0);
    chk("t3_m3525", mem[11*W + 5], 0);
    end_pass(3);

    // Pause for 10 cycles while WRITE is pending.
    load_img(1);
    w0 = n_writes;
    run_pass(1'b1, cyc);
    chk("t4_cycles", cyc, 4*NPIX + 1 + 10);
    chk("t4_cnt", fill_count, 1);
    chk("t4_writes", n_writes - w0, 1);
    chk("t4_mem", mem[2880], 1);
    end_pass(1);

    // Abort mid-pass after the fill, then restart from the top.
    load_img(1);
    w0 = n_writes;
    enable = 1'b1;
    for (int i = 0; i < 6000 && n_writes == w0; i++) @(negedge clk);
    repeat (7) @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_addr", ram_bus.address, 0);
    chk("t5_wren", ram_bus.wren, 0);
    chk("t5_data", ram_bus.data_write, 0);
    chk("t5_done", done, 0);
    chk("t5_cnt_hold", fill_count, 1);
    repeat (5) @(negedge clk);
    chk("t5_writes", n_writes - w0, 1);
    // 2880 is already 1 now, so the restarted pass fills nothing.
    w0 = n_writes;
    run_pass(1'b0, cyc);
    chk("t5r_cycles", cyc, 4*NPIX);
    chk("t5r_cnt", fill_count, 0);
    chk("t5r_writes", n_writes - w0, 0);
    end_pass(0);

    // Reset asserted between edges while in WRITE.
    load_img(1);
    w0 = n_writes;
    enable = 1'b1;
    for (int i = 0; i < 6000 && !ram_bus.wren; i++) @(negedge clk);
    chk("t6_in_write", ram_bus.wren, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_wren", ram_bus.wren, 0);
    chk("t6_addr", ram_bus.address, 0);
    chk("t6_cnt", fill_count, 0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_addr", ram_bus.address, 0);
    chk("t6_idle_done", done, 0);
    chk("t6_writes", n_writes - w0, 0);
    chk("t6_mem", mem[2880], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
